lut_neuron_loader: RTL and testbench
====================================

Name: lut_neuron_loader

Overview:
Runtime-programmable counterpart of the fixed-ROM LUT neurons. Instead of a synthesised truth table, this block accepts a serial stream of packed truth-table words and writes them into a distributed-RAM LUT. Once the full table is written, it serves registered lookups of the same form: IN_BITS address in, OUT_BITS activation out. It sits between the configuration bus (writer side) and the layer datapath (lookup side), so one bitstream can be reused for retrained ensembles.

Parameters:
IN_BITS, 6, LUT address width (fan-in × input bit width)
OUT_BITS, 2, output activation width
PACK, 4, table entries per config word; 2**IN_BITS must be divisible by PACK

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
cfg_start  input  1  one-cycle pulse; begins or restarts a table load
cfg_valid  input  1  config word valid
cfg_data  input  PACK*OUT_BITS  packed entries, LSB-first: entry k at bits [k*OUT_BITS +: OUT_BITS]
cfg_ready  output  1  loader accepts a word this cycle
table_valid  output  1  full table written; lookups enabled
cfg_err  output  1  sticky; a word was offered outside LOAD
in_valid  input  1  lookup request
in_data  input  IN_BITS  lookup address
in_ready  output  1  equals table_valid
out_valid  output  1  lookup result valid
out_data  output  OUT_BITS  lookup result

Behaviour:
- Reset values: state EMPTY; word counter 0; cfg_ready 0; table_valid 0; cfg_err 0; out_valid 0; out_data 0. LUT storage has no reset; its contents are undefined until loaded.
- Terms: WORDS = 2**IN_BITS / PACK; word counter width = clog2(WORDS).
- EMPTY state:
  - cfg_ready = 0.
  - cfg_start → LOAD, counter cleared.
- LOAD state:
  - cfg_ready = 1.
  - Transfer occurs when cfg_valid && cfg_ready.
  - Each transfer writes entry k of cfg_data to LUT address counter*PACK + k, for all k, then increments the counter.
  - The transfer with counter == WORDS-1 moves to READY. table_valid rises the next cycle.
- READY state:
  - cfg_ready = 0; table_valid = 1.
  - cfg_start → LOAD: counter cleared, table_valid cleared the next cycle.
- cfg_start in LOAD: restart at counter 0. A word presented in the same cycle is ignored; cfg_start has priority.
- cfg_valid while cfg_ready = 0 and no cfg_start that cycle: word dropped, cfg_err set. cfg_err clears only on rst.
- Lookup:
  - Accepted when in_valid && in_ready.
  - out_valid and out_data are registered, with one-cycle latency: the result appears in the cycle after acceptance.
  - out_valid = 0 in any cycle following a non-accepted request.
  - out_data holds its last value when out_valid = 0.
  - Fully pipelined; back-to-back requests give back-to-back results.
- Load started while a lookup result is in flight: the in-flight result still completes, with the old data. in_ready drops on the cycle table_valid clears.
- Reset mid-load: returns to EMPTY. A fresh cfg_start and a full reload are required.
- No backpressure on the out side; the consumer must always accept.

Decomposition:
- Package lut_cfg_pkg holds:
  - state enum (EMPTY, LOAD, READY);
  - localparams WORDS and CNT_W, derived from IN_BITS and PACK;
  - function entry_slice(word, k).
- One sub-module, lut_dist_ram: PACK write lanes and one registered read port, carrying the rom_style distributed attribute. The FSM, counter and error logic stay in the top.

Test Plan:
- Reset then in_valid=1, in_data=6'h05 → in_ready=0, out_valid stays 0; cfg_ready=0, table_valid=0.
- cfg_start, then 16 words of 8'hE4 (entry[a] = a[1:0]) → cfg_ready high for exactly those 16 transfers; table_valid=1 one cycle after the 16th; lookups 6'h05→2'b01, 6'h3E→2'b10, 6'h0F→2'b11 one cycle after each, back-to-back.
- Reload with cfg_valid gaps: words alternating 8'h00/8'hFF with idle cycles between → table_valid low for the whole load; afterwards 6'h00→2'b00 and 6'h04→2'b11.
- cfg_start pulsed after 5 words, then 16 words of 8'h55 → counter restarts; all 64 addresses read 2'b01.
- cfg_valid=1 in READY with no cfg_start → cfg_err=1, table unchanged (6'h05 still reads the prior value); cfg_err stays 1 until rst.
- Assert rst asynchronously mid-load after 8 words → all outputs 0 immediately; table_valid stays 0 until a complete 16-word reload.

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// Shared types, sizing and entry unpacking for the runtime-loadable LUT neuron.
// Sizing is fixed here so the loader and its RAM agree on word count and lane layout.
package lut_cfg_pkg;

    localparam int LUT_IN_BITS  = 6;
    localparam int LUT_OUT_BITS = 2;
    localparam int LUT_PACK     = 4;

    localparam int WORDS = (2 ** LUT_IN_BITS) / LUT_PACK;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        READY
    } state_t;

    // Entries are packed LSB-first: entry k sits at bits [k*OUT_BITS +: OUT_BITS].
    function automatic logic [LUT_OUT_BITS-1:0] entry_slice(
        input logic [LUT_PACK*LUT_OUT_BITS-1:0] word,
        input int                               k
    );
        return word[k*LUT_OUT_BITS +: LUT_OUT_BITS];
    endfunction

endpackage

// File: rtl/lut_cfg_ram.sv
// Empty guard module; the LUT storage is lut_dist_ram in lut_neuron_loader_ram.sv.
// No latency: contains no logic.
// No backpressure: has no ports.
module lut_cfg_ram_unused_guard;
endmodule

// File: rtl/lut_neuron_loader_ram.sv
// Distributed LUT storage: PACK parallel write lanes, one registered read port.
// One-cycle read latency; no backpressure, reads and writes are never stalled.
module lut_dist_ram
    import lut_cfg_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we,
    input  logic [CNT_W-1:0]                 wr_word,
    input  logic [LUT_PACK*LUT_OUT_BITS-1:0] wr_data,
    input  logic                             rd_en,
    input  logic [LUT_IN_BITS-1:0]           rd_addr,
    output logic                             rd_valid,
    output logic [LUT_OUT_BITS-1:0]          rd_data
);

    (* rom_style = "distributed" *)
    logic [LUT_OUT_BITS-1:0] mem [2**LUT_IN_BITS];

    // Storage is deliberately unreset; contents are defined only after a full load.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < LUT_PACK; k++) begin
                mem[LUT_IN_BITS'(int'(wr_word) * LUT_PACK + k)] <= entry_slice(wr_data, k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/lut_neuron_loader.sv
// Runtime-programmable LUT neuron: serial table load, then registered lookups.
// Lookup latency 1 cycle; cfg side is ready only in LOAD, out side has no backpressure.
module lut_neuron_loader
    import lut_cfg_pkg::*;
#(
    parameter int IN_BITS  = LUT_IN_BITS,
    parameter int OUT_BITS = LUT_OUT_BITS,
    parameter int PACK     = LUT_PACK
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_start,
    input  logic                     cfg_valid,
    input  logic [PACK*OUT_BITS-1:0] cfg_data,
    output logic                     cfg_ready,
    output logic                     table_valid,
    output logic                     cfg_err,
    input  logic                     in_valid,
    input  logic [IN_BITS-1:0]       in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [OUT_BITS-1:0]      out_data
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             wr_en;
    logic             rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            cnt     <= '0;
            cfg_err <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (cfg_valid && !cfg_ready && !cfg_start) begin
                cfg_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_en     = 1'b0;
        cfg_ready = (state == LOAD);
        case (state)
            EMPTY: begin
                if (cfg_start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                end
            end
            LOAD: begin
                // A restart wins over a word offered in the same cycle.
                if (cfg_start) begin
                    cnt_nxt = '0;
                end else if (cfg_valid) begin
                    wr_en = 1'b1;
                    if (cnt == CNT_W'(WORDS - 1)) begin
                        state_nxt = READY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            READY: begin
                if (cfg_start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    assign table_valid = (state == READY);
    assign in_ready    = table_valid;
    assign rd_en       = in_valid && in_ready;

    lut_dist_ram u_ram (
        .clk      (clk),
        .rst      (rst),
        .we       (wr_en),
        .wr_word  (cnt),
        .wr_data  (cfg_data),
        .rd_en    (rd_en),
        .rd_addr  (in_data),
        .rd_valid (out_valid),
        .rd_data  (out_data)
    );

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Directed bench for lut_neuron_loader with a table-level reference model.
module tb_lut_neuron_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_start;
    logic       cfg_valid;
    logic [7:0] cfg_data;
    logic       cfg_ready;
    logic       table_valid;
    logic       cfg_err;
    logic       in_valid;
    logic [5:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_data;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lut_neuron_loader dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_start   (cfg_start),
        .cfg_valid   (cfg_valid),
        .cfg_data    (cfg_data),
        .cfg_ready   (cfg_ready),
        .table_valid (table_valid),
        .cfg_err     (cfg_err),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data)
    );

    // Reference: a table, a "loading" flag with a word tally, and a "table good" flag.
    logic [1:0] m_mem [64];
    bit         m_loading = 1'b0;
    bit         m_tbl     = 1'b0;
    bit         m_err     = 1'b0;
    bit         m_ov      = 1'b0;
    logic [1:0] m_od      = 2'b00;
    int         m_n       = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_loading = 1'b0;
            m_tbl     = 1'b0;
            m_err     = 1'b0;
            m_ov      = 1'b0;
            m_od      = 2'b00;
            m_n       = 0;
        end else begin
            m_ov = in_valid && m_tbl;
            if (m_ov) m_od = m_mem[in_data];
            if (cfg_start) begin
                m_loading = 1'b1;
                m_tbl     = 1'b0;
                m_n       = 0;
            end else if (cfg_valid && m_loading) begin
                for (int k = 0; k < 4; k++) m_mem[m_n*4 + k] = cfg_data[2*k +: 2];
                m_n++;
                if (m_n == 16) begin
                    m_loading = 1'b0;
                    m_tbl     = 1'b1;
                end
            end else if (cfg_valid) begin
                m_err = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cfg_ready",   {7'd0, cfg_ready},   {7'd0, m_loading});
        check("table_valid", {7'd0, table_valid}, {7'd0, m_tbl});
        check("in_ready",    {7'd0, in_ready},    {7'd0, m_tbl});
        check("cfg_err",     {7'd0, cfg_err},     {7'd0, m_err});
        check("out_valid",   {7'd0, out_valid},   {7'd0, m_ov});
        check("out_data",    {6'd0, out_data},    {6'd0, m_od});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] word, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = word;
            tick();
            cfg_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic lookup(input logic [5:0] addr, input logic [1:0] exp, input string name);
        in_valid = 1'b1;
        in_data  = addr;
        tick();
        check({name, "_valid"}, {7'd0, out_valid}, 8'd1);
        check(name, {6'd0, out_data}, {6'd0, exp});
    endtask

    initial begin
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        in_valid  = 1'b0;
        in_data   = 6'h00;
        #12 rst = 1'b0;

        // Lookups refused before any table exists
        in_valid = 1'b1;
        in_data  = 6'h05;
        tick();
        tick();
        check("empty_in_ready",  {7'd0, in_ready},    8'd0);
        check("empty_out_valid", {7'd0, out_valid},   8'd0);
        check("empty_cfg_ready", {7'd0, cfg_ready},   8'd0);
        check("empty_tv",        {7'd0, table_valid}, 8'd0);
        in_valid = 1'b0;

        // Identity-pattern table, back-to-back lookups
        start();
        check("load_cfg_ready", {7'd0, cfg_ready}, 8'd1);
        load(8'hE4, 15, 0);
        check("tv_before_last", {7'd0, table_valid}, 8'd0);
        load(8'hE4, 1, 0);
        check("tv_after_last", {7'd0, table_valid}, 8'd1);
        check("ready_cfg_rdy", {7'd0, cfg_ready},   8'd0);
        lookup(6'h05, 2'b01, "lk05");
        lookup(6'h3E, 2'b10, "lk3E");
        lookup(6'h0F, 2'b11, "lk0F");
        in_valid = 1'b0;
        tick();
        check("idle_out_valid", {7'd0, out_valid}, 8'd0);
        check("hold_out_data",  {6'd0, out_data},  8'h03);

        // Reload with gaps between words
        start();
        for (int i = 0; i < 16; i++) load((i % 2) ? 8'hFF : 8'h00, 1, 1 + (i % 2));
        lookup(6'h00, 2'b00, "gap00");
        lookup(6'h04, 2'b11, "gap04");
        in_valid = 1'b0;

        // Restart mid-load, including a word offered alongside cfg_start
        start();
        load(8'hAA, 5, 0);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'hAA;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        load(8'h55, 16, 0);
        for (int a = 0; a < 64; a++) lookup(6'(a), 2'b01, "all55");
        in_valid = 1'b0;

        // Word offered in READY is dropped and flagged
        load(8'h00, 1, 1);
        check("err_set", {7'd0, cfg_err}, 8'd1);
        lookup(6'h05, 2'b01, "after_err");
        in_valid = 1'b0;
        tick();
        check("err_sticky", {7'd0, cfg_err}, 8'd1);

        // Lookup in flight when a reload starts returns the old data
        in_valid  = 1'b1;
        in_data   = 6'h05;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("inflight_valid", {7'd0, out_valid}, 8'd1);
        check("inflight_data",  {6'd0, out_data},  8'h01);
        check("inflight_rdy",   {7'd0, in_ready},  8'd0);
        tick();
        check("inflight_drop",  {7'd0, out_valid}, 8'd0);
        in_valid = 1'b0;

        // Asynchronous reset mid-load
        load(8'hAA, 8, 0);
        #3 rst = 1'b1;
        #1;
        check("rst_cfg_ready", {7'd0, cfg_ready},   8'd0);
        check("rst_tv",        {7'd0, table_valid}, 8'd0);
        check("rst_err",       {7'd0, cfg_err},     8'd0);
        check("rst_out_valid", {7'd0, out_valid},   8'd0);
        check("rst_out_data",  {6'd0, out_data},    8'd0);
        check("rst_in_ready",  {7'd0, in_ready},    8'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        start();
        load(8'h1B, 15, 0);
        check("reload_tv_low", {7'd0, table_valid}, 8'd0);
        load(8'h1B, 1, 0);
        check("reload_tv_high", {7'd0, table_valid}, 8'd1);
        lookup(6'h05, 2'b10, "reload05");
        lookup(6'h00, 2'b11, "reload00");
        in_valid = 1'b0;
        tick();
        check("reload_err", {7'd0, cfg_err}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
